// File: rtl/rv_alu2_mdu.sv
// Iterative RV32M multiply/divide unit for the ALU2 stage.
// Ports: clk/reset, flush, start+funct3/ops/rd in; ready, valid, result, rd out.
module rv_alu2_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic [4:0]        rd;
  logic              neg;
  logic [XLEN-1:0]   dvs;
  logic [2*XLEN-1:0] acc;

  logic            sgn1, sgn2, neg_in;
  logic            div0, ovf, fast;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     r33;
  logic              ge;
  logic [XLEN-1:0]   rem_n;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, res;

  // Operand decode on the accepting cycle
  always_comb begin
    sgn1   = 1'b0;
    sgn2   = 1'b0;
    neg_in = 1'b0;
    unique case (i_funct3)
      3'd1, 3'd4: begin
        sgn1   = i_op1[XLEN-1];
        sgn2   = i_op2[XLEN-1];
        neg_in = sgn1 ^ sgn2;
      end
      3'd6: begin
        sgn1   = i_op1[XLEN-1];
        sgn2   = i_op2[XLEN-1];
        neg_in = sgn1;
      end
      3'd2: begin
        sgn1   = i_op1[XLEN-1];
        neg_in = sgn1;
      end
      default: ;
    endcase
  end

  assign mag1 = sgn1 ? -i_op1 : i_op1;
  assign mag2 = sgn2 ? -i_op2 : i_op2;

  assign div0 = i_funct3[2] && (i_op2 == '0);
  assign ovf  = i_funct3[2] && !i_funct3[0]
             && (i_op1 == {1'b1, {(XLEN-1){1'b0}}})
             && (i_op2 == '1);
  assign fast = div0 || ovf;

  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      div0:    fast_res = i_funct3[1] ? i_op1 : '1;
      default: fast_res = i_funct3[1]
                        ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    endcase
  end

  // One iteration step
  // Multiply: acc = {partial hi, remaining multiplier}, LSB first.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                 + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, MSB first.
  assign r33     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ge      = r33 >= {1'b0, dvs};
  assign rem_n   = ge ? (r33[XLEN-1:0] - dvs) : r33[XLEN-1:0];
  assign div_nxt = {rem_n, acc[XLEN-2:0], ge};

  assign acc_nxt = f3[2] ? div_nxt : mul_nxt;

  // Sign fix-up on the final step
  assign prod_fix = (neg && !f3[2]) ? -acc_nxt : acc_nxt;
  assign div_sel  = f3[1] ? acc_nxt[2*XLEN-1:XLEN]
                          : acc_nxt[XLEN-1:0];
  assign div_fix  = neg ? -div_sel : div_sel;

  always_comb begin
    res = '0;
    unique case (1'b1)
      f3[2]:         res = div_fix;
      (f3 == 3'd0):  res = prod_fix[XLEN-1:0];
      default:       res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // FSM: outputs
  always_comb begin
    o_ready = ((state == IDLE) && !i_start) || (state == DONE);
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt      <= '0;
      f3       <= '0;
      rd       <= '0;
      neg      <= 1'b0;
      dvs      <= '0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else begin
      o_valid <= 1'b0;
      if (!i_flush) begin
        unique case (state)
          IDLE: if (i_start) begin
            f3  <= i_funct3;
            rd  <= i_rd;
            neg <= neg_in;
            cnt <= CNT_W'(XLEN-1);
            if (i_funct3[2]) begin
              dvs <= mag2;
              acc <= {{XLEN{1'b0}}, mag1};
            end else begin
              dvs <= mag1;
              acc <= {{XLEN{1'b0}}, mag2};
            end
            if (fast) begin
              o_valid  <= 1'b1;
              o_result <= fast_res;
              o_rd     <= i_rd;
            end
          end
          CALC: begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              o_valid  <= 1'b1;
              o_result <= res;
              o_rd     <= rd;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_alu2_mdu.sv
// Directed bench for rv_alu2_mdu.
// Checks latency, ready shape, results, flush and async reset.
module tb_rv_alu2_mdu;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_in;
  logic        ready, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  rv_alu2_mdu dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_flush   (flush),
    .i_start   (start),
    .i_funct3  (funct3),
    .i_op1     (op1),
    .i_op2     (op2),
    .i_rd      (rd_in),
    .o_ready   (ready),
    .o_valid   (valid),
    .o_result  (result),
    .o_rd      (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [2:0] f,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] r,
                     input logic [31:0] exp,
                     input int exp_lat,
                     input string tag);
    int lat;
    int lowc;
    bit found;
    lat   = 0;
    lowc  = 0;
    found = 0;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op1    = a;
    op2    = b;
    rd_in  = r;
    #1;
    chk({tag, "_rdy_c0"}, {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    rd_in = 5'(~r);
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (valid) begin
        found = 1;
        lat   = k;
      end else if (!ready) begin
        lowc++;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, r});
    chk({tag, "_rdy_done"}, {31'd0, ready}, 32'd1);
    chk({tag, "_rdy_low"}, lowc, exp_lat - 1);
    @(negedge clk);
    chk({tag, "_vld_1cyc"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic no_valid(input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    start  = 1'b0;
    funct3 = '0;
    op1    = '0;
    op2    = '0;
    rd_in  = '0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
        32'hFFFF_FFEB, 33, "mul");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
        32'hFFFF_FFFE, 33, "mulhu");
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
        32'h0000_0000, 33, "mulh");
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
        32'hFFFF_FFFF, 33, "mulhsu");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9,
        32'hFFFF_FFFD, 33, "div");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10,
        32'hFFFF_FFFF, 33, "rem");
    run(3'd5, 32'd100, 32'd7, 5'd11,
        32'd14, 33, "divu");
    run(3'd5, 32'h1234, 32'd0, 5'd13,
        32'hFFFF_FFFF, 1, "divu0");
    run(3'd6, 32'h1234, 32'd0, 5'd14,
        32'h1234, 1, "rem0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
        32'h8000_0000, 1, "divovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
        32'h0000_0000, 1, "removf");

    // Flush mid multiply at cycle 10
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    op1    = 32'd3;
    op2    = 32'd5;
    rd_in  = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_rdy_c10", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_rdy_c11", {31'd0, ready}, 32'd1);
    chk("flush_vld_c11", {31'd0, valid}, 32'd0);
    no_valid("flush_no_valid");

    // Start and flush together
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'd5;
    op1    = 32'd50;
    op2    = 32'd0;
    rd_in  = 5'd21;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("sflush_rdy", {31'd0, ready}, 32'd1);
    no_valid("sflush_no_valid");

    run(3'd7, 32'd100, 32'd7, 5'd12,
        32'd2, 33, "remu");

    // Async reset in the middle of a divide
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd4;
    op1    = 32'd100;
    op2    = 32'd3;
    rd_in  = 5'd22;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", {27'd0, rd_out}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run(3'd5, 32'd9, 32'd3, 5'd23,
        32'd3, 33, "divu_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_alu2_mdu.md
Name: rv_alu2_mdu

Overview:
- Iterative RV32M multiply/divide unit in the ALU2 stage; the responder side of the pipeline controller's ALU2 ready/flush handshake.
- Accepts one M-extension op from ALU1 and holds o_ready low while computing, so the controller stalls decode/ALU1 and flushes write.
- Presents a one-cycle result to the write stage.
- Shift-add multiply and restoring divide; one result bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous abort, driven by the controller's ALU2 flush.
- i_start  input  1  valid M op present from ALU1 this cycle.
- i_funct3  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_op1  input  32  rs1 value.
- i_op2  input  32  rs2 value.
- i_rd  input  5  destination register.
- o_ready  output  1  to the controller's ALU2 ready input; low while an op occupies the unit.
- o_valid  output  1  result valid, one cycle.
- o_result  output  32  result data.
- o_rd  output  5  destination register of the result.

Behaviour:
- Reset (async, i_reset_n=0): state IDLE, counter 0, o_valid 0, o_result 0, o_rd 0, internal accumulators 0.
- States: IDLE, CALC, DONE.
- o_ready = (state==IDLE & !i_start) | state==DONE. It is combinational from i_start, so the start cycle already stalls upstream.
- IDLE -> CALC: i_start=1 and i_flush=0.
  - Latch funct3, rd and operand signs.
  - Latch |op| magnitudes for signed operands: DIV/REM/MULH use both; MULHSU uses op1 only.
  - Counter = 31.
- IDLE -> DONE (fast path, no CALC):
  - Divide by zero (op2==0, funct3 4..7): quotient 0xFFFFFFFF; remainder = op1.
  - Signed overflow (DIV/REM, op1==0x80000000, op2==0xFFFFFFFF): quotient 0x80000000; remainder 0.
- CALC:
  - Multiply: 64-bit product accumulator, one conditional add plus shift per cycle.
  - Divide: restoring; each cycle shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - Counter decrements; leave to DONE on the cycle the counter is 0 (32 CALC cycles).
- DONE:
  - o_valid=1 for exactly one cycle, o_result and o_rd registered.
  - Then go to IDLE. A new i_start in DONE is not accepted; it is accepted in IDLE the next cycle.
- Result selection:
  - MUL: product[31:0]; MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient; REM/REMU: remainder.
- Sign fix-up, applied in DONE entry:
  - Product negated if the two operand signs differ (MULH), or if op1 is negative (MULHSU).
  - Quotient negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Fix-up is never applied on the fast paths.
- Latency: start seen at cycle 0 -> o_valid at cycle 33; o_ready low cycles 0..32. Fast path: o_valid at cycle 1; o_ready low cycle 0 only.
- i_flush:
  - In any state, next state is IDLE and o_valid is 0 next cycle.
  - Flush with i_start in the same cycle: flush wins, the op is dropped.
  - Flush in DONE: o_valid is still 1 in that cycle; the write stage discards it.
- Reset asserted mid-operation: immediate IDLE with reset values, regardless of the clock.
- Operands are sampled only on the accepting cycle; later changes on i_op1/i_op2 have no effect.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), start at cycle 0 -> o_ready low cycles 0..32; o_valid at cycle 33 with o_result 0xFFFFFFEB and o_rd echoed.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF at cycle 1. REM 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0. In all four, o_ready low only at cycle 0.
- Start MUL, assert i_flush at cycle 10 -> IDLE at cycle 11, o_ready high (i_start=0), no o_valid ever. Same-cycle i_start+i_flush -> op ignored.
- Deassert i_reset_n asynchronously at cycle 15 of a DIV -> o_valid/o_result/o_rd 0 immediately. After release, a fresh DIVU 9/3 returns 3 at start+33.
